// File: rtl/tff_ctr_pkg.sv
// Shared types and helpers for the T-flip-flop counter controller.
// Optional feature macro used by the controller: TFF_CTR_DOWN_EN (adds up_dn / down-count).
package tff_ctr_pkg;

    // Controller state encoding
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        DONE  = 2'b10
    } ctr_state_t;

    // Width used for the clamp helper; callers zero-extend into it and truncate back
    localparam int CLAMP_W = 32;

    // Limit a load value to the legal count range 0..modulus-1
    function automatic logic [CLAMP_W-1:0] clamp_mod(
        input logic [CLAMP_W-1:0] din,
        input int unsigned        modulus
    );
        if (din >= modulus) begin
            return CLAMP_W'(modulus - 1);
        end
        return din;
    endfunction

endpackage

// File: rtl/tff_counter_ctrl_tff.sv
// Single T flip-flop with complementary output; one instance per counter bit.
module tff (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q,
    output logic qb
);

    // Toggle on t, clear asynchronously on rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

    assign qb = ~q;

endmodule

// File: rtl/tff_counter_ctrl.sv
// Run/stop controller driving a bank of WIDTH T flip-flops as a mod-MODULUS counter.
// Every change to q (step, wrap, load, restart) is expressed as a toggle vector t = q ^ next_q.
// Define TFF_CTR_DOWN_EN to add the up_dn port and down-counting.
module tff_counter_ctrl #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             oneshot,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
`ifdef TFF_CTR_DOWN_EN
    input  logic             up_dn,
`endif
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy,
    output logic             done
);
    import tff_ctr_pkg::*;

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam int unsigned      MOD_U   = MODULUS;

    ctr_state_t       state_reg, state_next;
    logic             oneshot_latched_reg, oneshot_latched_next;
    logic             busy_reg, done_reg;
    logic [WIDTH-1:0] qb;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] restart_val;
    logic [WIDTH-1:0] load_val;
    logic             at_term;

    // Counter bits: q comes straight from the flip-flops, no shadow register
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            tff u_tff (
                .clk (clk),
                .rst (rst),
                .t   (t[gi]),
                .q   (q[gi]),
                .qb  (qb[gi])
            );
        end
    endgenerate

    // Direction-dependent terminal value, wrap step and restart value
`ifdef TFF_CTR_DOWN_EN
    assign term        = up_dn ? MAX_VAL : '0;
    assign restart_val = up_dn ? '0 : MAX_VAL;
    assign step_val    = up_dn ? (at_term ? '0 : q + WIDTH'(1))
                               : (at_term ? MAX_VAL : q - WIDTH'(1));
`else
    assign term        = MAX_VAL;
    assign restart_val = '0;
    assign step_val    = at_term ? '0 : q + WIDTH'(1);
`endif

    // q == term, evaluated bitwise from the complementary outputs (qb_i ^ term_i is 1 where bits match)
    assign at_term  = &(qb ^ term);
    assign load_val = WIDTH'(clamp_mod(CLAMP_W'(din), MOD_U));

    // Next state / next count, priority load > stop > start > count step
    always_comb begin
        state_next           = state_reg;
        oneshot_latched_next = oneshot_latched_reg;
        q_next               = q;
        if (load) begin
            q_next = load_val;
        end else if (stop) begin
            state_next = IDLE;
        end else if (start && (state_reg != COUNT)) begin
            state_next           = COUNT;
            oneshot_latched_next = oneshot;
            if (state_reg == DONE) begin
                q_next = restart_val;
            end
        end else if (state_reg == COUNT) begin
            if (oneshot_latched_reg && at_term) begin
                state_next = DONE;
            end else begin
                q_next = step_val;
            end
        end
    end

    // Toggle exactly the bits that differ between current and next value
    assign t = q ^ q_next;

    // FSM state, oneshot latch and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg           <= IDLE;
            oneshot_latched_reg <= 1'b0;
            busy_reg            <= 1'b0;
            done_reg            <= 1'b0;
        end else begin
            state_reg           <= state_next;
            oneshot_latched_reg <= oneshot_latched_next;
            busy_reg            <= (state_next == COUNT);
            done_reg            <= (state_next == DONE);
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign tc   = (state_reg == COUNT) && at_term;

endmodule

// File: tb/tb_tff_counter_ctrl.sv
// Directed, scoreboard-checked bench for tff_counter_ctrl (WIDTH=4, MODULUS=10).
module tb_tff_counter_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       oneshot = 1'b0;
    logic       load = 1'b0;
    logic [3:0] din = 4'd0;
`ifdef TFF_CTR_DOWN_EN
    logic       up_dn = 1'b1;
`endif
    logic [3:0] q;
    logic       tc, busy, done;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0] q;
        logic       busy;
        logic       done;
        logic       tc;
        string      tag;
    } exp_t;

    exp_t sb[$];

    tff_counter_ctrl #(.WIDTH(4), .MODULUS(10)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .oneshot (oneshot),
        .load    (load),
        .din     (din),
`ifdef TFF_CTR_DOWN_EN
        .up_dn   (up_dn),
`endif
        .q       (q),
        .tc      (tc),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        $display("[TB] %s: q=%0d busy=%0b done=%0b tc=%0b (exp q=%0d busy=%0b done=%0b tc=%0b)",
                 e.tag, q, busy, done, tc, e.q, e.busy, e.done, e.tc);
        tests++;
        assert (q === e.q) else begin
            fails++;
            $error("FAIL %s.q observed=%0d expected=%0d", e.tag, q, e.q);
        end
        tests++;
        assert (busy === e.busy) else begin
            fails++;
            $error("FAIL %s.busy observed=%0b expected=%0b", e.tag, busy, e.busy);
        end
        tests++;
        assert (done === e.done) else begin
            fails++;
            $error("FAIL %s.done observed=%0b expected=%0b", e.tag, done, e.done);
        end
        tests++;
        assert (tc === e.tc) else begin
            fails++;
            $error("FAIL %s.tc observed=%0b expected=%0b", e.tag, tc, e.tc);
        end
    endtask

    // Drive one cycle of inputs, record expectation, sample 1 time unit after the edge
    task automatic step(input logic s, input logic p, input logic l, input logic os,
                        input logic [3:0] d, input logic [3:0] eq, input logic eb,
                        input logic ed, input logic et, input string tag);
        start   = s;
        stop    = p;
        load    = l;
        oneshot = os;
        din     = d;
        sb.push_back('{q: eq, busy: eb, done: ed, tc: et, tag: tag});
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic check_now(input logic [3:0] eq, input logic eb, input logic ed,
                             input logic et, input string tag);
        sb.push_back('{q: eq, busy: eb, done: ed, tc: et, tag: tag});
        check_out();
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_now(4'd0, 1'b0, 1'b0, 1'b0, "reset");
        rst = 1'b0;

        // Free-run from 0: start, then 1..9, 0, 1
        step(0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0, "idle_hold");
        step(1, 0, 0, 0, 4'd0, 4'd0, 1, 0, 0, "start_free");
        for (int i = 1; i <= 9; i++) begin
            step(0, 0, 0, 0, 4'd0, 4'(i), 1, 0, (i == 9), "free_run");
        end
        step(0, 0, 0, 0, 4'd0, 4'd0, 1, 0, 0, "free_wrap");
        step(0, 0, 0, 0, 4'd0, 4'd1, 1, 0, 0, "free_after_wrap");

        // Load clamp during COUNT: no step on load edge, then wrap to 0
        step(0, 0, 1, 0, 4'hE, 4'd9, 1, 0, 1, "load_clamp");
        step(0, 0, 0, 0, 4'd0, 4'd0, 1, 0, 0, "post_load_wrap");
        step(0, 0, 0, 0, 4'd0, 4'd1, 1, 0, 0, "post_load_step");

        // start+stop together: stop wins in COUNT and in IDLE
        step(1, 1, 0, 0, 4'd0, 4'd1, 0, 0, 0, "startstop_count");
        step(0, 0, 0, 0, 4'd0, 4'd1, 0, 0, 0, "idle_hold2");
        step(1, 1, 0, 0, 4'd0, 4'd1, 0, 0, 0, "startstop_idle");

        // One-shot from 7; oneshot input dropped mid-count must not matter
        step(0, 0, 1, 0, 4'd7, 4'd7, 0, 0, 0, "load7_idle");
        step(1, 0, 0, 1, 4'd0, 4'd7, 1, 0, 0, "start_oneshot");
        step(0, 0, 0, 0, 4'd0, 4'd8, 1, 0, 0, "oneshot_8");
        step(0, 0, 0, 0, 4'd0, 4'd9, 1, 0, 1, "oneshot_9");
        step(0, 0, 0, 0, 4'd0, 4'd9, 0, 1, 0, "oneshot_done");
        step(0, 0, 0, 0, 4'd0, 4'd9, 0, 1, 0, "done_hold");

        // Restart from DONE goes to 0
        step(1, 0, 0, 0, 4'd0, 4'd0, 1, 0, 0, "restart_done");
        step(0, 0, 0, 0, 4'd0, 4'd1, 1, 0, 0, "restart_1");
        step(0, 0, 0, 0, 4'd0, 4'd2, 1, 0, 0, "restart_2");

        // Stop holds q, start resumes from held value
        step(0, 1, 0, 0, 4'd0, 4'd2, 0, 0, 0, "stop_hold");
        step(1, 0, 0, 0, 4'd0, 4'd2, 1, 0, 0, "resume");
        step(0, 0, 0, 0, 4'd0, 4'd3, 1, 0, 0, "resume_3");
        step(0, 0, 0, 0, 4'd0, 4'd4, 1, 0, 0, "resume_4");
        step(0, 0, 0, 0, 4'd0, 4'd5, 1, 0, 0, "resume_5");

        // Asynchronous reset between edges at q=5
        #1 rst = 1'b1;
        #1 check_now(4'd0, 1'b0, 1'b0, 1'b0, "async_reset");
        #1 rst = 1'b0;
        step(0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0, "no_resume");

`ifdef TFF_CTR_DOWN_EN
        // Down count from 2, then flip to up at 8
        up_dn = 1'b0;
        step(0, 0, 1, 0, 4'd2, 4'd2, 0, 0, 0, "dn_load2");
        step(1, 0, 0, 0, 4'd0, 4'd2, 1, 0, 0, "dn_start");
        step(0, 0, 0, 0, 4'd0, 4'd1, 1, 0, 0, "dn_1");
        step(0, 0, 0, 0, 4'd0, 4'd0, 1, 0, 1, "dn_0");
        step(0, 0, 0, 0, 4'd0, 4'd9, 1, 0, 0, "dn_9");
        step(0, 0, 0, 0, 4'd0, 4'd8, 1, 0, 0, "dn_8");
        up_dn = 1'b1;
        step(0, 0, 0, 0, 4'd0, 4'd9, 1, 0, 1, "up_9");
        step(0, 0, 0, 0, 4'd0, 4'd0, 1, 0, 0, "up_0");
`endif

        tests++;
        assert (sb.size() == 0) else begin
            fails++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety net so the run always terminates
    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
